mul_operand_feeder: RTL and testbench

Upstream sequencer for the repeated-addition multiplier. Buffers operand pairs in a small FIFO and drives the multiplier's `start` and shared 16-bit `data_in` bus in the exact cycle order the multiplier controller expects: A, then B. Waits for `done`, captures the product, presents it on a valid/ready result port, then pulses a restart so the multiplier returns to its idle state.

---
 rtl/mul_operand_feeder.sv | 148 ++++++++++++++
 tb/tb_mul_operand_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_feeder.sv
// mul_operand_feeder: FIFO-buffered A-then-B operand sequencer for the repeated-addition multiplier.
// Define MUL_FEED_TIMEOUT_EN to compile in a bounded WAIT that ends with out_err=1.
module mul_operand_feeder #(
  parameter int unsigned DW      = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          mul_start,
  output logic [DW-1:0] mul_data,
  input  logic          mul_done,
  input  logic [DW-1:0] mul_product,
  output logic          mul_restart,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_product,
  output logic          out_err,
  output logic          busy
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD_A, LOAD_B, WAIT, RESULT, RESTART} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] fifo_a [DEPTH];
  logic [DW-1:0] fifo_b [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [DW-1:0] head_a, head_b;
  logic [DW-1:0] a_reg, b_reg;
  logic          start_d, valid_d, timed_out;
  logic [DW-1:0] data_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push   = in_valid && !full;
  assign pop    = (state == IDLE) && !empty;
  assign head_a = fifo_a[rd_ptr[AW-1:0]];
  assign head_b = fifo_b[rd_ptr[AW-1:0]];

  assign in_ready    = !full;
  assign busy        = (state != IDLE) || !empty;
  assign mul_restart = (state == RESTART) || !rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr[AW-1:0]] <= in_a;
      fifo_b[wr_ptr[AW-1:0]] <= in_b;
    end
  end

`ifdef MUL_FEED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + CW'(1);
  end

  assign timed_out = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          out_err <= 1'b0;
    else if (state == WAIT && mul_done)  out_err <= 1'b0;
    else if (timed_out)                  out_err <= 1'b1;
  end
`else
  assign timed_out = 1'b0;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = WAIT;
      WAIT:    if (mul_done || timed_out) state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = RESTART;
      RESTART: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state; ISSUE is only ever
  // entered from IDLE on a pop, so its A operand comes straight from the head.
  always_comb begin
    start_d = 1'b0;
    data_d  = '0;
    valid_d = 1'b0;
    unique case (state_nxt)
      ISSUE: begin
        start_d = 1'b1;
        data_d  = head_a;
      end
      LOAD_A:       data_d  = a_reg;
      LOAD_B, WAIT: data_d  = b_reg;
      RESULT:       valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start   <= 1'b0;
      mul_data    <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else begin
      mul_start <= start_d;
      mul_data  <= data_d;
      out_valid <= valid_d;
      if (pop) begin
        a_reg <= head_a;
        b_reg <= head_b;
      end
      if (state == WAIT && mul_done) out_product <= mul_product;
      else if (timed_out)            out_product <= '0;
    end
  end
endmodule

// File: tb/tb_mul_operand_feeder.sv
// tb_mul_operand_feeder: directed operand/handshake scenarios checked every cycle against a
// queue-based transaction model, plus literal spot checks of the specified sequences.
module tb_mul_operand_feeder;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 15;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          in_valid = 1'b0, mul_done = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0, mul_product = '0;
  logic          in_ready, mul_start, mul_restart, out_valid, out_err, busy;
  logic [DW-1:0] mul_data, out_product;

  int n_cmp = 0;
  int n_bad = 0;

  mul_operand_feeder #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
    .mul_product(mul_product), .mul_restart(mul_restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction model: queued pairs plus the step of the current operation
  // (0 none, 1 start, 2 A again, 3 B, 4 awaiting done, 5 result held, 6 restart).
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  int            step = 0;
  int            wait_n = 0;
  logic [DW-1:0] cur_a = '0, cur_b = '0, m_prod = '0;
  logic          m_err = 1'b0;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    step   = 0;
    wait_n = 0;
    cur_a  = '0;
    cur_b  = '0;
    m_prod = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    bit take;
    if (!rst_n) begin
      model_reset();
      return;
    end
    take = in_valid && (q_a.size() < DEPTH);
    case (step)
      0: if (q_a.size() != 0) begin
        cur_a = q_a.pop_front();
        cur_b = q_b.pop_front();
        step  = 1;
      end
      1, 2: step = step + 1;
      3: begin
        step   = 4;
        wait_n = 0;
      end
      4: begin
        wait_n = wait_n + 1;
        if (mul_done) begin
          m_prod = mul_product;
          m_err  = 1'b0;
          step   = 5;
        end
`ifdef MUL_FEED_TIMEOUT_EN
        else if (wait_n == TO) begin
          m_prod = '0;
          m_err  = 1'b1;
          step   = 5;
        end
`endif
      end
      5: if (out_ready) step = 6;
      default: step = 0;
    endcase
    if (take) begin
      q_a.push_back(in_a);
      q_b.push_back(in_b);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready",    in_ready,    q_a.size() < DEPTH);
    chk("busy",        busy,        step != 0 || q_a.size() != 0);
    chk("mul_start",   mul_start,   step == 1);
    chk("mul_data",    mul_data,    (step == 1 || step == 2) ? cur_a :
                                    (step == 3 || step == 4) ? cur_b : '0);
    chk("mul_restart", mul_restart, step == 6 || !rst_n);
    chk("out_valid",   out_valid,   step == 5);
    chk("out_product", out_product, m_prod);
    chk("out_err",     out_err,     m_err);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (n_bad=%0d)", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic push1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which mul_start is high.
  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_start_seen"}, ok, 1);
  endtask

  // From the start cycle, raise mul_done in WAIT cycle k; returns in RESULT.
  task automatic finish_op(input string name, input int k, input logic [DW-1:0] prod);
    tick(2 + k);
    mul_done    = 1'b1;
    mul_product = prod;
    tick();
    mul_done    = 1'b0;
    mul_product = '0;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_prod"}, out_product, prod);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    chk({name, "_restart_pulse"}, mul_restart, 1);
    out_ready = 1'b0;
    tick();
    chk({name, "_restart_end"}, mul_restart, 0);
    chk({name, "_valid_end"}, out_valid, 0);
  endtask

  initial begin
    int acc_seen;

    // Reset state
    #2 rst_n = 1'b0;
    tick();
    chk("rst_restart", mul_restart, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", mul_data, 0);
    #2 rst_n = 1'b1;
    tick();

    // Single operation 3 x 4, done in the 5th WAIT cycle
    push1(16'd3, 16'd4);
    wait_start("t1");
    chk("t1_data0", mul_data, 3);
    tick();
    chk("t1_start1", mul_start, 0);
    chk("t1_data1", mul_data, 3);
    tick();
    chk("t1_data2", mul_data, 4);
    tick();
    chk("t1_data3", mul_data, 4);
    tick(4);
    chk("t1_valid_pre", out_valid, 0);
    mul_done    = 1'b1;
    mul_product = 16'd12;
    tick();
    mul_done    = 1'b0;
    mul_product = '0;
    chk("t1_valid", out_valid, 1);
    chk("t1_prod", out_product, 12);
    chk("t1_err", out_err, 0);
    handshake("t1");
    chk("t1_idle_busy", busy, 0);

    // Result held with out_ready low for 10 cycles
    push1(16'd7, 16'd9);
    wait_start("t3");
    finish_op("t3", 1, 16'd63);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_prod", out_product, 63);
      chk("t3_hold_restart", mul_restart, 0);
      tick();
    end
    handshake("t3");

    // mul_done pulses during ISSUE and LOAD_A are ignored
    push1(16'd5, 16'd6);
    wait_start("t4");
    mul_done    = 1'b1;
    mul_product = 16'h0BAD;
    tick(2);
    mul_done    = 1'b0;
    mul_product = '0;
    tick(2);
    chk("t4_not_done", out_valid, 0);
    chk("t4_in_wait_data", mul_data, 6);
    tick();
    mul_done    = 1'b1;
    mul_product = 16'd30;
    tick();
    mul_done    = 1'b0;
    mul_product = '0;
    chk("t4_valid", out_valid, 1);
    chk("t4_prod", out_product, 30);
    handshake("t4");

    // FIFO fill from reset with in_valid held and mul_done low
    apply_reset();
    acc_seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_a = 16'h0100 + DW'(acc_seen);
      in_b = 16'h0200 + DW'(acc_seen);
      if (in_ready) acc_seen++;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_accepted", acc_seen, 5);
    chk("t2_full", in_ready, 0);
    chk("t2_first_b", mul_data, 16'h0200);
    mul_done    = 1'b1;
    mul_product = 16'd1;
    tick();
    mul_done    = 1'b0;
    mul_product = '0;
    chk("t2_prod0", out_product, 1);
    handshake("t2a");
    for (int i = 1; i < 5; i++) begin
      wait_start("t2");
      chk("t2_order_a", mul_data, 16'h0100 + DW'(i));
      finish_op("t2", 1, DW'(i + 1));
      handshake("t2");
    end
    tick();
    chk("t2_drained_busy", busy, 0);

    // Reset while in WAIT with two pairs still queued
    in_valid = 1'b1;
    in_a = 16'h11; in_b = 16'h22; tick();
    in_a = 16'h33; in_b = 16'h44; tick();
    in_a = 16'h55; in_b = 16'h66; tick();
    in_valid = 1'b0;
    tick(3);
    chk("t5_wait_data", mul_data, 16'h22);
    chk("t5_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_start", mul_start, 0);
    chk("t5_rst_data", mul_data, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_prod", out_product, 0);
    chk("t5_rst_err", out_err, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_restart", mul_restart, 1);
    tick(2);
    #2 rst_n = 1'b1;
    tick(10);
    chk("t5_after_busy", busy, 0);
    chk("t5_after_valid", out_valid, 0);

`ifdef MUL_FEED_TIMEOUT_EN
    // Timeout after 15 WAIT cycles, then done exactly on the 15th
    push1(16'd8, 16'd8);
    wait_start("t6");
    tick(17);
    chk("t6_pre_valid", out_valid, 0);
    tick();
    chk("t6_valid", out_valid, 1);
    chk("t6_err", out_err, 1);
    chk("t6_prod", out_product, 0);
    handshake("t6");
    push1(16'd2, 16'd2);
    wait_start("t7");
    finish_op("t7", 15, 16'd77);
    chk("t7_err", out_err, 0);
    handshake("t7");
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
